branch_recovery_ctrl: RTL and testbench

Sequences branch misprediction recovery in the pipelined RISC-V core. Records each branch prediction issued at IF in an in-order queue and matches it against the outcome resolved in EX. On a mismatch it issues a redirect PC and a timed IF/ID flush. Every resolved outcome is also sent back to the jump predictor as a counter-update command.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/pred_queue.sv | 80 ++++++++
 rtl/branch_recovery_ctrl.sv | 174 +++++++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for branch misprediction recovery.
// Contents: B-format opcode constant, recovery FSM state type, the
// prediction queue entry payload and a saturating 16-bit increment helper.
package branch_pkg;

  localparam int unsigned PRED_PC_SIZE = 12;

  localparam logic [6:0] B_FORMAT_OP_CODE = 7'b1100011;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } recovery_state_t;

  // One outstanding prediction: branch address, predicted direction and the
  // PC to fetch if that direction proves wrong.
  typedef struct packed {
    logic [PRED_PC_SIZE-1:0] pc;
    logic                    taken;
    logic [PRED_PC_SIZE-1:0] alt_pc;
  } pred_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of outstanding branch predictions.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   push        - write push_entry at the tail (ignored when full or clear)
//   push_entry  - entry to write
//   pop         - drop the head entry (ignored when empty or clear)
//   clear       - empty the queue; overrides push and pop
//   head        - oldest entry (undefined while empty)
//   count       - number of stored entries, 0..DEPTH
//   full, empty - count==DEPTH / count==0
module pred_queue
  import branch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  pred_entry_t   push_entry,
  input  logic          pop,
  input  logic          clear,
  output pred_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  pred_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery sequencer.
// Queues IF predictions in order, matches each against the EX outcome, and on
// a mismatch issues a one-cycle redirect plus an IF/ID flush lasting
// FLUSH_CYCLES cycles. Every resolved branch produces a predictor update.
// Optional feature macro: PERF_CNT_EN (saturating branch/mispredict counters;
// when undefined both perf outputs are tied to 0).
// Ports:
//   CLK, RESET_N                      - clock, async active-low reset
//   pred_valid/pc/taken/alt_pc        - prediction issued at IF
//   res_valid/res_taken               - outcome of the oldest branch from EX
//   stall_if                          - queue full (combinational)
//   redirect_valid/redirect_pc        - recovery PC load pulse
//   flush_if/flush_id                 - squash IF/ID and ID/EX
//   upd_valid/upd_pc/upd_correct      - predictor counter update
//   protocol_err                      - sticky protocol violation flag
//   perf_branches/perf_mispredicts    - performance counters
module branch_recovery_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned PC_SIZE      = PRED_PC_SIZE,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               pred_valid,
  input  logic [PC_SIZE-1:0] pred_pc,
  input  logic               pred_taken,
  input  logic [PC_SIZE-1:0] pred_alt_pc,
  input  logic               res_valid,
  input  logic               res_taken,
  output logic               stall_if,
  output logic               redirect_valid,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic               flush_if,
  output logic               flush_id,
  output logic               upd_valid,
  output logic [PC_SIZE-1:0] upd_pc,
  output logic               upd_correct,
  output logic               protocol_err,
  output logic [15:0]        perf_branches,
  output logic [15:0]        perf_mispredicts
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  recovery_state_t    state_q;
  logic [FCW-1:0]     flush_cnt_q;
  logic               flush_q;
  logic               redirect_valid_q;
  logic [PC_SIZE-1:0] redirect_pc_q;
  logic               upd_valid_q;
  logic [PC_SIZE-1:0] upd_pc_q;
  logic               upd_correct_q;
  logic               protocol_err_q, protocol_err_d;

  pred_entry_t        q_head;
  pred_entry_t        push_entry_c;
  logic [CW-1:0]      q_count;
  logic               q_full, q_empty;

  logic               in_run_c, pop_c, push_c, mispredict_c, err_set_c;

  // Request decode: a mispredicting pop makes any same-cycle push wrong-path.
  always_comb begin
    in_run_c     = (state_q == RUN);
    pop_c        = in_run_c && res_valid && !q_empty;
    mispredict_c = pop_c && (res_taken != q_head.taken);
    push_c       = in_run_c && pred_valid && !q_full && !mispredict_c;
    err_set_c    = (in_run_c && res_valid && q_empty) || (pred_valid && q_full);
    push_entry_c = '{pc:     PRED_PC_SIZE'(pred_pc),
                     taken:  pred_taken,
                     alt_pc: PRED_PC_SIZE'(pred_alt_pc)};
  end

  pred_queue #(
    .DEPTH (DEPTH)
  ) u_pred_queue (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .clear      (mispredict_c),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign protocol_err_d = protocol_err_q | err_set_c;

  // Recovery FSM and registered redirect/flush/update outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= RUN;
      flush_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_correct_q    <= 1'b0;
      protocol_err_q   <= 1'b0;
    end else begin
      upd_valid_q      <= pop_c;
      upd_pc_q         <= pop_c ? PC_SIZE'(q_head.pc) : '0;
      upd_correct_q    <= pop_c && !mispredict_c;
      redirect_valid_q <= 1'b0;
      protocol_err_q   <= protocol_err_d;
      case (state_q)
        RUN: begin
          if (mispredict_c) begin
            state_q          <= FLUSH;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= PC_SIZE'(q_head.alt_pc);
            flush_q          <= 1'b1;
            flush_cnt_q      <= FCW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          // flush_cnt_q holds the flush cycles still to come after this one.
          if (flush_cnt_q == '0) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FCW'(1);
          end
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_if       = (q_count == CW'(DEPTH));
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = flush_q;
  assign flush_id       = flush_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_correct    = upd_correct_q;
  assign protocol_err   = protocol_err_q;

`ifdef PERF_CNT_EN
  logic [15:0] perf_br_q, perf_br_d;
  logic [15:0] perf_mis_q, perf_mis_d;

  assign perf_br_d  = pop_c        ? sat_inc16(perf_br_q)  : perf_br_q;
  assign perf_mis_d = mispredict_c ? sat_inc16(perf_mis_q) : perf_mis_q;

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Self-checking bench for branch_recovery_ctrl: a reference queue model
// predicts update/redirect/flush traffic into scoreboards that are compared
// one cycle after each resolve.
module tb_branch_recovery_ctrl;
  import branch_pkg::*;

  localparam int unsigned PCW          = 12;
  localparam int unsigned DEPTH        = 4;
  localparam int          FLUSH_CYCLES = 2;

  logic           CLK;
  logic           RESET_N;
  logic           pred_valid;
  logic [PCW-1:0] pred_pc;
  logic           pred_taken;
  logic [PCW-1:0] pred_alt_pc;
  logic           res_valid;
  logic           res_taken;
  logic           stall_if;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           flush_if;
  logic           flush_id;
  logic           upd_valid;
  logic [PCW-1:0] upd_pc;
  logic           upd_correct;
  logic           protocol_err;
  logic [15:0]    perf_branches;
  logic [15:0]    perf_mispredicts;

  branch_recovery_ctrl #(
    .PC_SIZE      (PCW),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_alt_pc      (pred_alt_pc),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .stall_if         (stall_if),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_correct      (upd_correct),
    .protocol_err     (protocol_err),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [PCW-1:0] pc;
    logic           correct;
  } upd_exp_t;

  int             vectors    = 0;
  int             miscompares = 0;
  upd_exp_t       sb_upd[$];
  logic [PCW-1:0] sb_redir[$];
  pred_entry_t    mq[$];
  int             m_flush;
  logic           m_err;
  int unsigned    m_br;
  int unsigned    m_mis;

  task automatic model_reset();
    sb_upd.delete();
    sb_redir.delete();
    mq.delete();
    m_flush = 0;
    m_err   = 1'b0;
    m_br    = 0;
    m_mis   = 0;
  endtask

  // One clock of stimulus: the model predicts, the DUT is clocked, and the
  // scoreboards are drained and compared #1 after the edge.
  task automatic step(input logic pv, input logic [PCW-1:0] pc, input logic pt,
                      input logic [PCW-1:0] alt, input logic rv, input logic rt);
    bit             run, pop, mis, push;
    pred_entry_t    e;
    upd_exp_t       u;
    logic [PCW-1:0] rpc;
    run  = (m_flush == 0);
    pop  = run && rv && (mq.size() > 0);
    mis  = pop && (rt != mq[0].taken);
    push = run && pv && (mq.size() < DEPTH) && !mis;
    if ((run && rv && mq.size() == 0) || (pv && mq.size() == DEPTH)) m_err = 1'b1;
    if (pop) begin
      u.pc      = mq[0].pc;
      u.correct = !mis;
      sb_upd.push_back(u);
      if (m_br < 65535) m_br++;
      if (mis) begin
        sb_redir.push_back(mq[0].alt_pc);
        if (m_mis < 65535) m_mis++;
      end
    end
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = pc; e.taken = pt; e.alt_pc = alt;
        mq.push_back(e);
      end
    end
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_alt_pc = alt;
    res_valid  = rv; res_taken = rt;
    @(posedge CLK);
    #1;
    if (m_flush > 0) m_flush--;
    vectors++;
    if (sb_upd.size() > 0) begin
      u = sb_upd.pop_front();
      if (upd_valid !== 1'b1 || upd_pc !== u.pc || upd_correct !== u.correct) begin
        miscompares++;
        $display("FAIL upd: got v=%b pc=%h c=%b, want v=1 pc=%h c=%b @%0t",
                 upd_valid, upd_pc, upd_correct, u.pc, u.correct, $time);
      end
    end else if (upd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL upd_spurious: got upd_valid=%b, want 0 @%0t", upd_valid, $time);
    end
    vectors++;
    if (sb_redir.size() > 0) begin
      rpc = sb_redir.pop_front();
      m_flush = FLUSH_CYCLES;
      if (redirect_valid !== 1'b1 || redirect_pc !== rpc) begin
        miscompares++;
        $display("FAIL redirect: got v=%b pc=%h, want v=1 pc=%h @%0t",
                 redirect_valid, redirect_pc, rpc, $time);
      end
    end else if (redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_spurious: got redirect_valid=%b, want 0 @%0t", redirect_valid, $time);
    end
    vectors++;
    if (flush_if !== (m_flush > 0) || flush_id !== (m_flush > 0)) begin
      miscompares++;
      $display("FAIL flush: got if=%b id=%b, want %b @%0t", flush_if, flush_id, (m_flush > 0), $time);
    end
    vectors++;
    if (stall_if !== (mq.size() == DEPTH)) begin
      miscompares++;
      $display("FAIL stall_if: got %b, want %b @%0t", stall_if, (mq.size() == DEPTH), $time);
    end
    vectors++;
    if (protocol_err !== m_err) begin
      miscompares++;
      $display("FAIL protocol_err: got %b, want %b @%0t", protocol_err, m_err, $time);
    end
    vectors++;
`ifdef PERF_CNT_EN
    if (perf_branches !== 16'(m_br) || perf_mispredicts !== 16'(m_mis)) begin
      miscompares++;
      $display("FAIL perf: got br=%0d mis=%0d, want br=%0d mis=%0d @%0t",
               perf_branches, perf_mispredicts, m_br, m_mis, $time);
    end
`else
    if (perf_branches !== 16'h0 || perf_mispredicts !== 16'h0) begin
      miscompares++;
      $display("FAIL perf_tied: got br=%0d mis=%0d, want 0 0 @%0t",
               perf_branches, perf_mispredicts, $time);
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_alt_pc = '0;
    res_valid  = 1'b0; res_taken = 1'b0;
    RESET_N = 1'b0;
    #3;
    vectors++;
    if (stall_if !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== '0 ||
        flush_if !== 1'b0 || flush_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got stall=%b rv=%b rpc=%h fif=%b fid=%b, want all 0",
               stall_if, redirect_valid, redirect_pc, flush_if, flush_id);
    end
    vectors++;
    if (upd_valid !== 1'b0 || upd_pc !== '0 || upd_correct !== 1'b0 || protocol_err !== 1'b0 ||
        perf_branches !== 16'h0 || perf_mispredicts !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_upd: got uv=%b upc=%h uc=%b err=%b br=%0d mis=%0d, want all 0",
               upd_valid, upd_pc, upd_correct, protocol_err, perf_branches, perf_mispredicts);
    end
    model_reset();
    RESET_N = 1'b1;
  endtask

  task automatic test_correct_prediction();
    step(1'b1, 12'h010, 1'b1, 12'h014, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (upd_valid !== 1'b1 || upd_pc !== 12'h010 || upd_correct !== 1'b1 || flush_if !== 1'b0) begin
      miscompares++;
      $display("FAIL correct_pred: got uv=%b upc=%h uc=%b flush=%b, want 1 010 1 0",
               upd_valid, upd_pc, upd_correct, flush_if);
    end
    idle(2);
  endtask

  task automatic test_mispredict();
    step(1'b1, 12'h020, 1'b0, 12'h080, 1'b0, 1'b0);
    step(1'b1, 12'h024, 1'b1, 12'h028, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 12'h080 || flush_if !== 1'b1 ||
        upd_correct !== 1'b0 || upd_pc !== 12'h020) begin
      miscompares++;
      $display("FAIL mispredict: got rv=%b rpc=%h flush=%b uc=%b upc=%h, want 1 080 1 0 020",
               redirect_valid, redirect_pc, flush_if, upd_correct, upd_pc);
    end
    idle(3);
    // Queue must have been cleared: exactly four more pushes fill it.
    step(1'b1, 12'h200, 1'b1, 12'h300, 1'b0, 1'b0);
    step(1'b1, 12'h204, 1'b0, 12'h304, 1'b0, 1'b0);
    step(1'b1, 12'h208, 1'b1, 12'h308, 1'b0, 1'b0);
    vectors++;
    if (stall_if !== 1'b0) begin
      miscompares++;
      $display("FAIL cleared_3: got stall_if=%b, want 0", stall_if);
    end
    step(1'b1, 12'h20C, 1'b0, 12'h30C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_same_cycle_discard();
    step(1'b1, 12'h040, 1'b0, 12'h0A0, 1'b0, 1'b0);
    step(1'b1, 12'h044, 1'b1, 12'h048, 1'b1, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (protocol_err !== 1'b1 || upd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle: got err=%b uv=%b, want 1 0", protocol_err, upd_valid);
    end
  endtask

  task automatic test_full();
    step(1'b1, 12'h100, 1'b1, 12'h180, 1'b0, 1'b0);
    step(1'b1, 12'h104, 1'b0, 12'h184, 1'b0, 1'b0);
    step(1'b1, 12'h108, 1'b1, 12'h188, 1'b0, 1'b0);
    step(1'b1, 12'h10C, 1'b0, 12'h18C, 1'b0, 1'b0);
    step(1'b1, 12'h110, 1'b1, 12'h190, 1'b0, 1'b0);
    vectors++;
    if (stall_if !== 1'b1 || protocol_err !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drop: got stall=%b err=%b, want 1 1", stall_if, protocol_err);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 12'h114, 1'b1, 12'h194, 1'b1, 1'b0);
    vectors++;
    if (stall_if !== 1'b0 || upd_pc !== 12'h104) begin
      miscompares++;
      $display("FAIL push_pop_same: got stall=%b upc=%h, want 0 104", stall_if, upd_pc);
    end
    step(1'b1, 12'h118, 1'b0, 12'h198, 1'b0, 1'b0);
    vectors++;
    if (stall_if !== 1'b1) begin
      miscompares++;
      $display("FAIL refill: got stall=%b, want 1", stall_if);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid_flush();
    step(1'b1, 12'h050, 1'b1, 12'h054, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    vectors++;
    if (flush_if !== 1'b0 || flush_id !== 1'b0 || redirect_valid !== 1'b0 ||
        upd_valid !== 1'b0 || stall_if !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flush: got fif=%b fid=%b rv=%b uv=%b stall=%b, want all 0",
               flush_if, flush_id, redirect_valid, upd_valid, stall_if);
    end
    model_reset();
    #1 RESET_N = 1'b1;
    step(1'b1, 12'h060, 1'b0, 12'h064, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (upd_valid !== 1'b1 || upd_pc !== 12'h060 || upd_correct !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset: got uv=%b upc=%h uc=%b, want 1 060 1", upd_valid, upd_pc, upd_correct);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic           pv, pt, rv, rt;
    logic [PCW-1:0] pc;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH);
      rv = ($urandom_range(0, 2) != 0) && (mq.size() > 0);
      pt = 1'($urandom_range(0, 1));
      pc = PCW'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) rt = mq[0].taken;
      else rt = 1'($urandom_range(0, 1));
      step(pv, pc, pt, pc + PCW'(4), rv, rt);
    end
    idle(3);
  endtask

  task automatic test_perf();
`ifdef PERF_CNT_EN
    step(1'b1, 12'h400, 1'b1, 12'h404, 1'b0, 1'b0);
    step(1'b1, 12'h408, 1'b0, 12'h40C, 1'b0, 1'b0);
    step(1'b1, 12'h410, 1'b1, 12'h414, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 12'h420, 1'b0, 12'h424, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (perf_branches !== 16'd3 || perf_mispredicts !== 16'd1) begin
      miscompares++;
      $display("FAIL perf_count: got br=%0d mis=%0d, want 3 1", perf_branches, perf_mispredicts);
    end
    step(1'b1, 12'h430, 1'b1, 12'h434, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 12'h430, 1'b1, 12'h434, 1'b1, 1'b1);
    vectors++;
    if (perf_branches !== 16'hFFFF || perf_mispredicts !== 16'd1) begin
      miscompares++;
      $display("FAIL perf_sat: got br=%h mis=%0d, want FFFF 1", perf_branches, perf_mispredicts);
    end
`else
    step(1'b1, 12'h400, 1'b1, 12'h404, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    vectors++;
    if (perf_branches !== 16'h0 || perf_mispredicts !== 16'h0) begin
      miscompares++;
      $display("FAIL perf_off: got br=%0d mis=%0d, want 0 0", perf_branches, perf_mispredicts);
    end
`endif
  endtask

  initial begin
    RESET_N = 1'b1;
    #1;
    test_reset();
    test_correct_prediction();
    test_mispredict();
    test_same_cycle_discard();
    test_reset();
    test_full();
    test_reset();
    test_reset_mid_flush();
    test_reset();
    test_back_to_back();
    test_reset();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
